// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencer for the 5-stage core: register enables, flushes, data-memory
// handshake with watchdog, and stall/flush performance counters.
module pipeline_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             MemRead_EX,
  input  logic [4:0]       RD_EX,
  input  logic [4:0]       RS_ID,
  input  logic [4:0]       RT_ID,
  input  logic             use_rs_ID,
  input  logic             use_rt_ID,
  input  logic             branch_taken_EX,
  input  logic             MemRead_MEM,
  input  logic             MemWrite_MEM,
  input  logic             dmem_ack,
  output logic             dmem_req,
  output logic             PC_write,
  output logic             IF_ID_write,
  output logic             ID_EX_write,
  output logic             EX_MEM_write,
  output logic             MEM_WB_write,
  output logic             IF_ID_flush,
  output logic             ID_EX_flush,
  output logic             mem_error,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    ERROR = 2'd2
  } state_t;

  localparam logic [16:0] TIMEOUT = 17'(MEM_TIMEOUT);

  state_t           state_r;
  state_t           state_nxt_s;
  logic [16:0]      wait_cnt_r;
  logic [16:0]      wait_cnt_nxt_s;
  logic [CNT_W-1:0] stall_cnt_r;
  logic [CNT_W-1:0] flush_cnt_r;

  logic mem_acc_s;
  logic load_use_s;
  logic mem_stall_s;
  logic req_s;
  logic err_s;
  logic active_s;
  logic lu_stall_s;
  logic br_flush_s;

  assign mem_acc_s  = MemRead_MEM | MemWrite_MEM;
  assign load_use_s = MemRead_EX & (RD_EX != 5'd0) &
                      ((use_rs_ID & (RS_ID == RD_EX)) | (use_rt_ID & (RT_ID == RD_EX)));

  // Memory handshake FSM next-state, wait counter and memory-stall decode.
  always_comb begin
    state_nxt_s    = state_r;
    wait_cnt_nxt_s = wait_cnt_r;
    mem_stall_s    = 1'b0;
    req_s          = 1'b0;
    err_s          = 1'b0;
    case (state_r)
      IDLE: begin
        req_s = mem_acc_s;
        if (mem_acc_s && !dmem_ack) begin
          // This cycle is already the first wait cycle.
          mem_stall_s    = 1'b1;
          wait_cnt_nxt_s = 17'd1;
          state_nxt_s    = (TIMEOUT == 17'd1) ? ERROR : WAIT;
        end else begin
          wait_cnt_nxt_s = 17'd0;
        end
      end
      WAIT: begin
        req_s = 1'b1;
        if (dmem_ack) begin
          state_nxt_s    = IDLE;
          wait_cnt_nxt_s = 17'd0;
        end else begin
          mem_stall_s    = 1'b1;
          wait_cnt_nxt_s = wait_cnt_r + 17'd1;
          if (wait_cnt_r + 17'd1 >= TIMEOUT) begin
            state_nxt_s = ERROR;
          end else begin
            state_nxt_s = WAIT;
          end
        end
      end
      ERROR: begin
        err_s = 1'b1;
      end
      default: begin
        state_nxt_s    = IDLE;
        wait_cnt_nxt_s = 17'd0;
      end
    endcase
  end

  assign active_s   = !reset && (state_r != ERROR);
  assign br_flush_s = active_s && !mem_stall_s && branch_taken_EX;
  assign lu_stall_s = active_s && !mem_stall_s && !branch_taken_EX && load_use_s;

  // Enable/flush priority: memory stall, then branch flush, then load-use bubble.
  always_comb begin
    dmem_req     = 1'b0;
    PC_write     = 1'b0;
    IF_ID_write  = 1'b0;
    ID_EX_write  = 1'b0;
    EX_MEM_write = 1'b0;
    MEM_WB_write = 1'b0;
    IF_ID_flush  = 1'b0;
    ID_EX_flush  = 1'b0;
    mem_error    = 1'b0;
    if (reset) begin
      dmem_req = 1'b0;
    end else if (!active_s) begin
      mem_error = err_s;
    end else if (mem_stall_s) begin
      dmem_req = req_s;
    end else if (branch_taken_EX) begin
      dmem_req     = req_s;
      PC_write     = 1'b1;
      IF_ID_write  = 1'b1;
      ID_EX_write  = 1'b1;
      EX_MEM_write = 1'b1;
      MEM_WB_write = 1'b1;
      IF_ID_flush  = 1'b1;
      ID_EX_flush  = 1'b1;
    end else if (load_use_s) begin
      dmem_req     = req_s;
      ID_EX_write  = 1'b1;
      EX_MEM_write = 1'b1;
      MEM_WB_write = 1'b1;
      ID_EX_flush  = 1'b1;
    end else begin
      dmem_req     = req_s;
      PC_write     = 1'b1;
      IF_ID_write  = 1'b1;
      ID_EX_write  = 1'b1;
      EX_MEM_write = 1'b1;
      MEM_WB_write = 1'b1;
    end
  end

  // State, wait counter and wrapping performance counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      wait_cnt_r  <= 17'd0;
      stall_cnt_r <= '0;
      flush_cnt_r <= '0;
    end else begin
      state_r    <= state_nxt_s;
      wait_cnt_r <= wait_cnt_nxt_s;
      if (mem_stall_s || lu_stall_s) begin
        stall_cnt_r <= stall_cnt_r + CNT_W'(1);
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (br_flush_s) begin
        flush_cnt_r <= flush_cnt_r + CNT_W'(1);
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

  assign stall_cnt = stall_cnt_r;
  assign flush_cnt = flush_cnt_r;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench: stimulus pushes hand-computed expectations, a negedge monitor checks them.
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b1;
  logic        reset;
  logic        MemRead_EX, use_rs_ID, use_rt_ID, branch_taken_EX;
  logic [4:0]  RD_EX, RS_ID, RT_ID;
  logic        MemRead_MEM, MemWrite_MEM, dmem_ack;
  logic        dmem_req, PC_write, IF_ID_write, ID_EX_write, EX_MEM_write, MEM_WB_write;
  logic        IF_ID_flush, ID_EX_flush, mem_error;
  logic [31:0] stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .MemRead_EX(MemRead_EX), .RD_EX(RD_EX), .RS_ID(RS_ID), .RT_ID(RT_ID),
    .use_rs_ID(use_rs_ID), .use_rt_ID(use_rt_ID), .branch_taken_EX(branch_taken_EX),
    .MemRead_MEM(MemRead_MEM), .MemWrite_MEM(MemWrite_MEM), .dmem_ack(dmem_ack),
    .dmem_req(dmem_req), .PC_write(PC_write), .IF_ID_write(IF_ID_write),
    .ID_EX_write(ID_EX_write), .EX_MEM_write(EX_MEM_write), .MEM_WB_write(MEM_WB_write),
    .IF_ID_flush(IF_ID_flush), .ID_EX_flush(ID_EX_flush), .mem_error(mem_error),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // {dmem_req, PC, IF_ID, ID_EX, EX_MEM, MEM_WB, IF_ID_flush, ID_EX_flush, mem_error}
  localparam logic [8:0] ZERO     = 9'b0_00000_00_0;
  localparam logic [8:0] NORM     = 9'b0_11111_00_0;
  localparam logic [8:0] NORM_REQ = 9'b1_11111_00_0;
  localparam logic [8:0] MSTALL   = 9'b1_00000_00_0;
  localparam logic [8:0] LU       = 9'b0_00111_01_0;
  localparam logic [8:0] BR       = 9'b0_11111_11_0;
  localparam logic [8:0] BR_REQ   = 9'b1_11111_11_0;
  localparam logic [8:0] ERRV     = 9'b0_00000_00_1;

  typedef struct {
    logic [8:0]  ctl;
    logic [31:0] stall;
    logic [31:0] flush;
    string       name;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  logic [8:0] act_ctl;
  assign act_ctl = {dmem_req, PC_write, IF_ID_write, ID_EX_write, EX_MEM_write,
                    MEM_WB_write, IF_ID_flush, ID_EX_flush, mem_error};

  // Monitor: compare every presented cycle against the oldest expectation.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (act_ctl !== e.ctl) begin
        errors++;
        $display("FAIL %s ctl: got=%b expected=%b", e.name, act_ctl, e.ctl);
      end
      checks++;
      if (stall_cnt !== e.stall) begin
        errors++;
        $display("FAIL %s stall_cnt: got=%0d expected=%0d", e.name, stall_cnt, e.stall);
      end
      checks++;
      if (flush_cnt !== e.flush) begin
        errors++;
        $display("FAIL %s flush_cnt: got=%0d expected=%0d", e.name, flush_cnt, e.flush);
      end
    end
  end

  task automatic set_in(input logic mr_ex, input logic [4:0] rd, input logic [4:0] rs,
                        input logic [4:0] rt, input logic urs, input logic urt,
                        input logic br, input logic mrm, input logic mwm, input logic ack);
    MemRead_EX = mr_ex; RD_EX = rd; RS_ID = rs; RT_ID = rt;
    use_rs_ID = urs; use_rt_ID = urt; branch_taken_EX = br;
    MemRead_MEM = mrm; MemWrite_MEM = mwm; dmem_ack = ack;
  endtask

  task automatic step(input logic [8:0] ctl, input logic [31:0] s, input logic [31:0] f,
                      input string name);
    exp_t e;
    e.ctl = ctl; e.stall = s; e.flush = f; e.name = name;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(ZERO, 32'd0, 32'd0, "rst_hold");
    reset = 1'b0;
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(NORM, 32'd0, 32'd0, "idle");
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    step(NORM_REQ, 32'd0, 32'd0, "zero_wait");
    // 3-cycle write access
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(MSTALL, 32'd0, 32'd0, "mem3_c1");
    step(MSTALL, 32'd1, 32'd0, "mem3_c2");
    dmem_ack = 1'b1;
    step(NORM_REQ, 32'd2, 32'd0, "mem3_c3");
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(NORM, 32'd2, 32'd0, "mem3_after");
    // load-use variants
    set_in(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(LU, 32'd2, 32'd0, "lu_rs");
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(NORM, 32'd3, 32'd0, "lu_done");
    set_in(1'b1, 5'd7, 5'd3, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(LU, 32'd3, 32'd0, "lu_rt");
    set_in(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(NORM, 32'd4, 32'd0, "lu_rd0");
    set_in(1'b1, 5'd5, 5'd5, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(NORM, 32'd4, 32'd0, "lu_nouse");
    // branch overrides load-use
    set_in(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(BR, 32'd4, 32'd0, "br_lu");
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(NORM, 32'd4, 32'd1, "br_after");
    // branch held during a memory wait, ack on the last cycle before timeout
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(MSTALL, 32'd4, 32'd1, "brw_c1");
    step(MSTALL, 32'd5, 32'd1, "brw_c2");
    step(MSTALL, 32'd6, 32'd1, "brw_c3");
    dmem_ack = 1'b1;
    step(BR_REQ, 32'd7, 32'd1, "brw_ack");
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(NORM, 32'd7, 32'd2, "brw_after");
    // watchdog: four wait cycles without ack
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(MSTALL, 32'd7, 32'd2, "wd_c1");
    step(MSTALL, 32'd8, 32'd2, "wd_c2");
    step(MSTALL, 32'd9, 32'd2, "wd_c3");
    step(MSTALL, 32'd10, 32'd2, "wd_c4");
    set_in(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(ERRV, 32'd11, 32'd2, "err_enter");
    dmem_ack = 1'b1;
    step(ERRV, 32'd11, 32'd2, "err_ack");
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(ERRV, 32'd11, 32'd2, "err_sticky");
    reset = 1'b1;
    step(ZERO, 32'd0, 32'd0, "rst_from_err");
    reset = 1'b0;
    // async reset in the middle of a wait
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(MSTALL, 32'd0, 32'd0, "w2_c1");
    step(MSTALL, 32'd1, 32'd0, "w2_c2");
    reset = 1'b1;
    step(ZERO, 32'd0, 32'd0, "rst_mid_wait");
    reset = 1'b0;
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(NORM, 32'd0, 32'd0, "ack_ignored");
    dmem_ack = 1'b0;
    step(NORM, 32'd0, 32'd0, "final_idle");
    for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got=%0d pending expected=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
